register_file_multi_port_write_32b_1r_128b: RTL and testbench



---
 rtl/register_file_pkg.sv | 21 ++
 rtl/rf_write_arbiter.sv | 43 ++++
 rtl/register_file_multi_port_write_32b_1r_128b.sv | 108 ++++++++++
 tb/tb_register_file_multi_port_write_32b_1r_128b.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared widths and the write-sample record for the narrow-write / wide-read register file.
package register_file_pkg;

  localparam int unsigned RfRaddrWidth = 5;
  localparam int unsigned RfRdataWidth = 128;
  localparam int unsigned RfWdataWidth = 32;
  localparam int unsigned RfNWrite     = 4;

  localparam int unsigned N_LANES  = RfRdataWidth / RfWdataWidth;
  localparam int unsigned NUM_ROWS = 2 ** RfRaddrWidth;

  // Lane address: row in the upper bits, lane within the row in the lower bits.
  localparam int unsigned RfWaddrWidth = RfRaddrWidth + $clog2(N_LANES);

  typedef struct packed {
    logic                    valid;
    logic [RfWaddrWidth-1:0] addr;
    logic [RfWdataWidth-1:0] data;
  } write_req_t;

endpackage

// File: rtl/rf_write_arbiter.sv
// Resolves same-lane write collisions (lowest port index wins) and produces per-lane
// write enables plus one-hot data selects.
module rf_write_arbiter
  import register_file_pkg::*;
#(
  parameter int unsigned NumPorts = RfNWrite,
  parameter int unsigned NumLanes = NUM_ROWS * N_LANES
) (
  input  write_req_t          req_i      [NumPorts],
  output logic [NumLanes-1:0] lane_we_o,
  output logic [NumPorts-1:0] lane_sel_o [NumLanes],
  output logic [NumPorts-1:0] conflict_o
);

  // A port loses whenever any lower-index valid port targets the same lane.
  always_comb begin
    conflict_o = '0;
    for (int p = 1; p < int'(NumPorts); p++) begin
      for (int q = 0; q < p; q++) begin
        if (req_i[p].valid && req_i[q].valid && (req_i[p].addr == req_i[q].addr)) begin
          conflict_o[p] = 1'b1;
        end
      end
    end
  end

  for (genvar a = 0; a < int'(NumLanes); a++) begin : gen_lane
    logic [NumPorts-1:0] sel;

    always_comb begin
      sel = '0;
      for (int p = 0; p < int'(NumPorts); p++) begin
        if (req_i[p].valid && !conflict_o[p] && (req_i[p].addr == RfWaddrWidth'(a))) begin
          sel[p] = 1'b1;
        end
      end
    end

    assign lane_sel_o[a] = sel;
    assign lane_we_o[a]  = |sel;
  end

endmodule

// File: rtl/register_file_multi_port_write_32b_1r_128b.sv
// Flip-flop register file: N_WRITE sampled 32b write ports committing one edge after
// sampling, one registered-address 128b read port.
module register_file_multi_port_write_32b_1r_128b
  import register_file_pkg::*;
#(
  parameter int unsigned RADDR_WIDTH = RfRaddrWidth,
  parameter int unsigned RDATA_WIDTH = RfRdataWidth,
  parameter int unsigned WDATA_WIDTH = RfWdataWidth,
  parameter int unsigned WADDR_WIDTH = RfWaddrWidth,
  parameter int unsigned N_WRITE     = RfNWrite
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_WRITE-1:0]                  WriteEnable,
  input  logic [N_WRITE-1:0][WADDR_WIDTH-1:0] WriteAddr,
  input  logic [N_WRITE-1:0][WDATA_WIDTH-1:0] WriteData,
  output logic [N_WRITE-1:0]                  WriteConflict,
  input  logic                                ReadEnable,
  input  logic [RADDR_WIDTH-1:0]              ReadAddr,
  output logic [RDATA_WIDTH-1:0]              ReadData
);

  localparam int unsigned NLanes     = RDATA_WIDTH / WDATA_WIDTH;
  localparam int unsigned LaneWidth  = $clog2(NLanes);
  localparam int unsigned TotalLanes = NLanes * (2 ** RADDR_WIDTH);

  write_req_t sample_d [N_WRITE];
  write_req_t sample_q [N_WRITE];

  logic [N_WRITE-1:0] conflict_d, conflict_q;
  logic [RADDR_WIDTH-1:0] raddr_d, raddr_q;

  logic [TotalLanes-1:0][WDATA_WIDTH-1:0] mem_d, mem_q;

  logic [TotalLanes-1:0] lane_we;
  logic [N_WRITE-1:0]    lane_sel [TotalLanes];

  // Idle ports drop their valid bit but keep the last address/data.
  always_comb begin
    for (int p = 0; p < int'(N_WRITE); p++) begin
      sample_d[p] = sample_q[p];
      if (WriteEnable[p]) begin
        sample_d[p] = '{valid: 1'b1, addr: WriteAddr[p], data: WriteData[p]};
      end else begin
        sample_d[p].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < int'(N_WRITE); p++) begin
        sample_q[p].valid <= 1'b0;
      end
    end else begin
      sample_q <= sample_d;
    end
  end

  rf_write_arbiter #(
    .NumPorts(N_WRITE),
    .NumLanes(TotalLanes)
  ) u_arbiter (
    .req_i     (sample_q),
    .lane_we_o (lane_we),
    .lane_sel_o(lane_sel),
    .conflict_o(conflict_d)
  );

  // Reset also suppresses a commit already in flight from stage 1.
  for (genvar a = 0; a < int'(TotalLanes); a++) begin : gen_mem
    logic [WDATA_WIDTH-1:0] wdata;

    always_comb begin
      wdata = '0;
      for (int p = 0; p < int'(N_WRITE); p++) begin
        wdata = wdata | (sample_q[p].data & {WDATA_WIDTH{lane_sel[a][p]}});
      end
    end

    assign mem_d[a] = (!rst && lane_we[a]) ? wdata : mem_q[a];
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    raddr_d = ReadEnable ? ReadAddr : raddr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= '0;
      raddr_q    <= '0;
    end else begin
      conflict_q <= conflict_d;
      raddr_q    <= raddr_d;
    end
  end

  assign WriteConflict = conflict_q;

  for (genvar k = 0; k < int'(NLanes); k++) begin : gen_rd
    assign ReadData[k*WDATA_WIDTH +: WDATA_WIDTH] = mem_q[{raddr_q, LaneWidth'(k)}];
  end

endmodule

// File: tb/tb_register_file_multi_port_write_32b_1r_128b.sv
// Directed plus randomized bench for the multi-port-write register file, checked against
// a lane-level memory model with a one-edge pending-write stage.
module tb_register_file_multi_port_write_32b_1r_128b;

  logic             clk;
  logic             rst;
  logic [3:0]       WriteEnable;
  logic [3:0][6:0]  WriteAddr;
  logic [3:0][31:0] WriteData;
  logic [3:0]       WriteConflict;
  logic             ReadEnable;
  logic [4:0]       ReadAddr;
  logic [127:0]     ReadData;

  register_file_multi_port_write_32b_1r_128b dut (
    .clk          (clk),
    .rst          (rst),
    .WriteEnable  (WriteEnable),
    .WriteAddr    (WriteAddr),
    .WriteData    (WriteData),
    .WriteConflict(WriteConflict),
    .ReadEnable   (ReadEnable),
    .ReadAddr     (ReadAddr),
    .ReadData     (ReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: lane storage, known-lane flags, writes waiting one edge to commit.
  logic [31:0] m_mem   [128];
  bit          m_known [128];
  bit   [3:0]  p_v;
  logic [6:0]  p_a     [4];
  logic [31:0] p_d     [4];
  logic [4:0]  m_raddr;
  logic [3:0]  m_conf;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_edge(input logic [3:0] we, input logic [3:0][6:0] wa,
                            input logic [3:0][31:0] wd, input logic re, input logic [4:0] ra,
                            input logic r);
    m_conf = '0;
    if (r) begin
      p_v     = '0;
      m_raddr = '0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (p_v[p]) begin
          for (int q = 0; q < p; q++) begin
            if (p_v[q] && p_a[q] == p_a[p]) m_conf[p] = 1'b1;
          end
        end
      end
      // Highest index first so the lowest-index writer is what remains.
      for (int p = 3; p >= 0; p--) begin
        if (p_v[p]) begin
          m_mem[p_a[p]]   = p_d[p];
          m_known[p_a[p]] = 1'b1;
        end
      end
      if (re) m_raddr = ra;
      for (int p = 0; p < 4; p++) begin
        p_v[p] = we[p];
        if (we[p]) begin
          p_a[p] = wa[p];
          p_d[p] = wd[p];
        end
      end
    end
  endtask

  task automatic step(input logic [3:0] we, input logic [3:0][6:0] wa,
                      input logic [3:0][31:0] wd, input logic re, input logic [4:0] ra,
                      input logic r);
    int idx;
    WriteEnable = we;
    WriteAddr   = wa;
    WriteData   = wd;
    ReadEnable  = re;
    ReadAddr    = ra;
    rst         = r;
    @(posedge clk);
    #1;
    model_edge(we, wa, wd, re, ra, r);
    check("conflict", {124'd0, WriteConflict}, {124'd0, m_conf});
    for (int k = 0; k < 4; k++) begin
      idx = int'(m_raddr) * 4 + k;
      if (m_known[idx]) begin
        check($sformatf("read row%0d lane%0d", m_raddr, k), {96'd0, ReadData[k*32 +: 32]},
              {96'd0, m_mem[idx]});
      end
    end
  endtask

  task automatic idle(input logic re, input logic [4:0] ra);
    step(4'd0, '0, '0, re, ra, 1'b0);
  endtask

  logic [3:0][6:0]  rwa;
  logic [3:0][31:0] rwd;

  initial begin
    for (int i = 0; i < 128; i++) begin
      m_known[i] = 1'b0;
      m_mem[i]   = '0;
    end
    p_v     = '0;
    m_raddr = '0;
    m_conf  = '0;

    step(4'd0, '0, '0, 1'b1, 5'd9, 1'b1);
    step(4'd0, '0, '0, 1'b0, 5'd0, 1'b1);

    // Single write, lane 1 of row 1.
    step(4'b0001, {7'd0, 7'd0, 7'd0, 7'h05}, {32'd0, 32'd0, 32'd0, 32'hAAAA0001}, 1'b0, 5'd0,
         1'b0);
    idle(1'b0, 5'd0);
    idle(1'b1, 5'd1);
    check("row1 lane1", {96'd0, ReadData[63:32]}, {96'd0, 32'hAAAA0001});

    // Four ports fill row 7 in one cycle.
    step(4'b1111, {7'd31, 7'd30, 7'd29, 7'd28},
         {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 1'b0, 5'd0, 1'b0);
    idle(1'b1, 5'd7);
    check("row7 full", ReadData, 128'h44444444_33333333_22222222_11111111);
    check("row7 noconf", {124'd0, WriteConflict}, 128'd0);

    // Ports 1 and 3 collide on lane 0x10.
    step(4'b1010, {7'h10, 7'd0, 7'h10, 7'd0}, {32'hDEAD, 32'd0, 32'hBEEF, 32'd0}, 1'b0, 5'd0,
         1'b0);
    idle(1'b1, 5'd4);
    check("conflict p3", {124'd0, WriteConflict}, {124'd0, 4'b1000});
    idle(1'b0, 5'd0);
    check("conflict clr", {124'd0, WriteConflict}, 128'd0);
    check("winner beef", {96'd0, ReadData[31:0]}, {96'd0, 32'h0000BEEF});

    // Held read row sees the commit edge, not the sample edge.
    step(4'b0001, {7'd0, 7'd0, 7'd0, 7'h08}, {32'd0, 32'd0, 32'd0, 32'h0BADF00D}, 1'b0, 5'd0,
         1'b0);
    idle(1'b1, 5'd2);
    step(4'b0100, {7'd0, 7'h08, 7'd0, 7'd0}, {32'd0, 32'h12345678, 32'd0, 32'd0}, 1'b0, 5'd0,
         1'b0);
    check("sample edge old", {96'd0, ReadData[31:0]}, {96'd0, 32'h0BADF00D});
    idle(1'b0, 5'd0);
    check("commit edge new", {96'd0, ReadData[31:0]}, {96'd0, 32'h12345678});

    // Reset one edge after a request discards it and returns the read row to 0.
    step(4'b0001, {7'd0, 7'd0, 7'd0, 7'h00}, {32'd0, 32'd0, 32'd0, 32'hCAFE0000}, 1'b0, 5'd0,
         1'b0);
    idle(1'b1, 5'd3);
    step(4'b0001, {7'd0, 7'd0, 7'd0, 7'h00}, {32'd0, 32'd0, 32'd0, 32'h0DEAD000}, 1'b0, 5'd0,
         1'b0);
    step(4'd0, '0, '0, 1'b1, 5'd5, 1'b1);
    check("rst raddr0", {96'd0, ReadData[31:0]}, {96'd0, 32'hCAFE0000});
    idle(1'b0, 5'd0);
    idle(1'b0, 5'd0);
    check("rst discard", {96'd0, ReadData[31:0]}, {96'd0, 32'hCAFE0000});

    // Back-to-back writes to one lane.
    idle(1'b1, 5'd16);
    step(4'b0010, {7'd0, 7'd0, 7'h41, 7'd0}, {32'd0, 32'd0, 32'h1, 32'd0}, 1'b0, 5'd0, 1'b0);
    step(4'b0010, {7'd0, 7'd0, 7'h41, 7'd0}, {32'd0, 32'd0, 32'h2, 32'd0}, 1'b0, 5'd0, 1'b0);
    check("b2b first", {96'd0, ReadData[63:32]}, {96'd0, 32'h1});
    idle(1'b0, 5'd0);
    check("b2b second", {96'd0, ReadData[63:32]}, {96'd0, 32'h2});

    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 4; p++) begin
        rwa[p] = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 7))
                                             : 7'($urandom_range(0, 127));
        rwd[p] = $urandom;
      end
      step(4'($urandom_range(0, 15)), rwa, rwd, ($urandom_range(0, 2) == 0),
           5'($urandom_range(0, 31)), ($urandom_range(0, 49) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
